demux_1_4_buf: RTL and testbench

- Buffered 1-to-4 demultiplexer: the distribution-side counterpart of the team's 4:1 byte multiplexer.
- Accepts one data stream with a 2-bit channel select over a valid/ready handshake.
- Routes each accepted word into one of four per-channel FIFOs; each FIFO drains independently through its own valid/ready output.
- Sits between a shared producer and four independent consumers.

---
 rtl/demux_1_4_buf.sv | 100 ++++++++++
 tb/tb_demux_1_4_buf.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/demux_1_4_buf.sv
// Buffered 1-to-4 demultiplexer.
// One valid/ready input stream carries a 2-bit channel select with each word.
// Each accepted word goes into one of four per-channel FIFOs. Each FIFO drains
// independently through its own first-word-fall-through valid/ready output.

// Per-channel FIFO. Its head entry is always presented on dout.
module demux_ch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop_req,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             wr;
    logic             rd;

    // The full check is repeated here so the FIFO protects itself
    // regardless of what the parent gates.
    assign wr    = push & ~full;
    assign rd    = pop_req & valid;
    assign valid = (cnt != '0);
    assign full  = (cnt == FULL_CNT);
    assign dout  = mem[rd_ptr];

    // Update the pointers, the occupancy and the storage.
    // A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module demux_1_4_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         S,
    input  logic [WIDTH-1:0]   A,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] F,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic               busy
);
    logic [3:0] full;

    // in_ready depends only on the selected channel's registered fullness.
    // It never depends on out_ready, so a full channel refuses a push
    // even in a cycle where it pops.
    assign in_ready = ~full[S];
    assign busy     = |out_valid;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic push;
        assign push = in_valid & in_ready & (S == 2'(g));

        demux_ch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push),
            .pop_req (out_ready[g]),
            .din     (A),
            .dout    (F[g*WIDTH +: WIDTH]),
            .valid   (out_valid[g]),
            .full    (full[g])
        );
    end
endmodule

// File: tb/tb_demux_1_4_buf.sv
// Self-checking bench for demux_1_4_buf.
// The model keeps one expected-word queue per channel. A word is pushed onto
// its queue when the model accepts the input, and popped when the output
// handshake completes. Table vectors add hand-derived in_ready and out_valid.
module tb_demux_1_4_buf;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic               clk;
    logic               rst;
    logic [1:0]         S;
    logic [WIDTH-1:0]   A;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] F;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic               busy;

    demux_1_4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .A         (A),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] q [4][$];

    typedef struct {
        logic       iv;
        logic [1:0] s;
        logic [7:0] a;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_vld;
    } vec_t;
    vec_t tbl [13];

    // Compare one DUT value against its required value.
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the inputs, let them settle, and compare the outputs with the model.
    task automatic drive(input logic iv, input logic [1:0] s, input logic [7:0] a,
                         input logic [3:0] ordy, input logic r);
        in_valid  = iv;
        S         = s;
        A         = a;
        out_ready = ordy;
        rst       = r;
        #1;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out_valid[%0d]", i), int'(out_valid[i]), int'(q[i].size() != 0));
                if (q[i].size() != 0)
                    chk($sformatf("F[%0d]", i), int'(F[i*WIDTH +: WIDTH]), int'(q[i][0]));
            end
            chk("in_ready", int'(in_ready), int'(q[s].size() != DEPTH));
            chk("busy", int'(busy), int'((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0));
        end
    endtask

    // Apply the clock edge to the model, then return at the falling edge.
    task automatic advance();
        logic acc;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) q[i].delete();
        end else begin
            acc = in_valid && (q[S].size() < DEPTH);
            for (int i = 0; i < 4; i++)
                if (out_ready[i] && q[i].size() != 0) void'(q[i].pop_front());
            if (acc) q[S].push_back(A);
        end
        @(negedge clk);
    endtask

    task automatic cycle(input logic iv, input logic [1:0] s, input logic [7:0] a,
                         input logic [3:0] ordy);
        drive(iv, s, a, ordy, 1'b0);
        advance();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'b0000};
        tbl[1]  = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0001};
        tbl[2]  = '{1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 4'b0010};
        tbl[3]  = '{1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 4'b0100};
        tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000};
        tbl[5]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 2'd2, 8'hA1, 4'h0, 1'b1, 4'b0000};
        tbl[7]  = '{1'b1, 2'd2, 8'hA2, 4'h0, 1'b1, 4'b0100};
        tbl[8]  = '{1'b1, 2'd2, 8'hA3, 4'h0, 1'b0, 4'b0100};
        tbl[9]  = '{1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 4'b0100};
        tbl[10] = '{1'b0, 2'd2, 8'h00, 4'h4, 1'b0, 4'b0100};
        tbl[11] = '{1'b0, 2'd2, 8'h00, 4'h4, 1'b1, 4'b0100};
        tbl[12] = '{1'b0, 2'd2, 8'h00, 4'h0, 1'b1, 4'b0000};

        // Reset, then check the idle state.
        in_valid = 1'b0; S = 2'd0; A = '0; out_ready = 4'h0; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset F", int'(F), 0);
        for (int s = 0; s < 4; s++) begin
            S = 2'(s);
            #1;
            chk($sformatf("reset in_ready S=%0d", s), int'(in_ready), 1);
        end
        @(negedge clk);

        // Table vectors: broadcast to the four channels, then fill channel 2 and drain it.
        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].iv, tbl[k].s, tbl[k].a, tbl[k].ordy, 1'b0);
            chk($sformatf("tbl%0d in_ready", k), int'(in_ready), int'(tbl[k].exp_rdy));
            chk($sformatf("tbl%0d out_valid", k), int'(out_valid), int'(tbl[k].exp_vld));
            advance();
        end

        // Channel 1 full: a pop in the same cycle does not open the input.
        cycle(1'b1, 2'd1, 8'h51, 4'h0);
        cycle(1'b1, 2'd1, 8'h52, 4'h0);
        drive(1'b1, 2'd1, 8'h5C, 4'h2, 1'b0);
        chk("full+pop in_ready", int'(in_ready), 0);
        advance();
        drive(1'b1, 2'd1, 8'h5C, 4'h0, 1'b0);
        chk("after pop in_ready", int'(in_ready), 1);
        advance();
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'd1, 8'h00, 4'h2);

        // Channel 3: a push and a pop in the same cycle, repeated enough to wrap the pointers.
        cycle(1'b1, 2'd3, 8'h7E, 4'h0);
        cycle(1'b1, 2'd3, 8'h7F, 4'h8);
        #1;
        chk("ch3 F after swap", int'(F[3*WIDTH +: WIDTH]), 8'h7F);
        chk("ch3 valid after swap", int'(out_valid[3]), 1);
        for (int k = 0; k < 8; k++) cycle(1'b1, 2'd3, 8'(8'h80 + k), 4'h8);
        cycle(1'b0, 2'd3, 8'h00, 4'h8);
        cycle(1'b0, 2'd3, 8'h00, 4'h8);

        // Reset in the middle of a stream.
        cycle(1'b1, 2'd0, 8'hC1, 4'h0);
        cycle(1'b1, 2'd0, 8'hC2, 4'h0);
        cycle(1'b1, 2'd2, 8'hC3, 4'h0);
        drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b1);
        advance();
        rst = 1'b0;
        #1;
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset F", int'(F), 0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, 8'h00, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
